// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-schedule sequencer: loads the external expander, captures all
// round keys into a local store and serves them by round in either direction.
module aes_key_sched_ctrl #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_vld,
    output logic         key_rdy,
    input  logic [127:0] key_in,
    output logic         kld,
    output logic [127:0] key_exp,
    input  logic [31:0]  wo_0,
    input  logic [31:0]  wo_1,
    input  logic [31:0]  wo_2,
    input  logic [31:0]  wo_3,
    output logic         rk_vld,
    input  logic         dec,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rk_out
);
    localparam int         NK   = NR + 1;
    localparam logic [3:0] LAST = 4'(NR);

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    state_t       state_reg, state_next;
    logic [3:0]   cnt_reg, cnt_next;
    logic         rk_vld_reg, rk_vld_next;
    logic [127:0] rk_out_reg;
    logic [127:0] store_q [NK];
    logic [127:0] wo_word;
    logic         accept;
    logic         idx_ok;
    logic [3:0]   eff_idx;

    assign wo_word = {wo_0, wo_1, wo_2, wo_3};
    assign key_rdy = (state_reg == IDLE) || (state_reg == DONE);
    assign accept  = key_vld & key_rdy;
    assign kld     = accept;
    assign key_exp = key_in;
    assign rk_vld  = rk_vld_reg;
    assign rk_out  = rk_out_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= 4'd0;
            rk_vld_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            rk_vld_reg <= rk_vld_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        rk_vld_next = rk_vld_reg;
        unique case (state_reg)
            IDLE, DONE: begin
                if (key_vld) begin
                    state_next  = EXPAND;
                    cnt_next    = 4'd0;
                    rk_vld_next = 1'b0;
                end
            end
            EXPAND: begin
                // The expander advances unconditionally, so capture every cycle
                // and stop with cnt parked on the last round.
                if (cnt_reg == LAST) begin
                    state_next  = DONE;
                    rk_vld_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    generate
        for (genvar gi = 0; gi < NK; gi++) begin : g_store
            logic [127:0] entry_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    entry_reg <= 128'h0;
                else if (state_reg == EXPAND && cnt_reg == 4'(gi))
                    entry_reg <= wo_word;
            end
            assign store_q[gi] = entry_reg;
        end
    endgenerate

    // Out-of-range requests are clamped to entry 0 before the mux and then zeroed.
    assign idx_ok  = (rd_idx <= LAST);
    assign eff_idx = !idx_ok ? 4'd0 : (dec ? (LAST - rd_idx) : rd_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rk_out_reg <= 128'h0;
        else if (rk_vld_reg && idx_ok)
            rk_out_reg <= store_q[eff_idx];
        else
            rk_out_reg <= 128'h0;
    end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: models the free-running AES-128 expander and
// checks captured round keys against an arithmetic key-expansion reference.
`timescale 1ns/1ps
module tb_aes_key_sched_ctrl;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         key_vld = 1'b0;
    logic         key_rdy;
    logic [127:0] key_in = 128'h0;
    logic         kld;
    logic [127:0] key_exp;
    logic [31:0]  wo_0, wo_1, wo_2, wo_3;
    logic         rk_vld;
    logic         dec = 1'b0;
    logic [3:0]   rd_idx = 4'd0;
    logic [127:0] rk_out;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    always #5 clk = ~clk;

    aes_key_sched_ctrl #(.NR(10)) dut (
        .clk(clk), .rst(rst), .key_vld(key_vld), .key_rdy(key_rdy),
        .key_in(key_in), .kld(kld), .key_exp(key_exp),
        .wo_0(wo_0), .wo_1(wo_1), .wo_2(wo_2), .wo_3(wo_3),
        .rk_vld(rk_vld), .dec(dec), .rd_idx(rd_idx), .rk_out(rk_out)
    );

    int checks = 0;
    int fails  = 0;

    logic [7:0]   sbox_tab [256];
    logic [127:0] exp_rk [11];
    logic [127:0] model_w;
    int           model_r = 0;
    int           kld_seen = 0;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] t;
        t = {v, v} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] rcon(input int n);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < n; i++) r = gmul(r, 8'h02);
        return r;
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8), then the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0) begin
                inv = 8'h01;
                repeat (254) inv = gmul(inv, 8'(x));
            end
            sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                          ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] next_round(input logic [127:0] w, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
        {w0, w1, w2, w3} = w;
        t  = {sbox_tab[w3[23:16]], sbox_tab[w3[15:8]], sbox_tab[w3[7:0]], sbox_tab[w3[31:24]]}
             ^ {rc, 24'h0};
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    task automatic calc_expected(input logic [127:0] key);
        exp_rk[0] = key;
        for (int r = 1; r <= 10; r++) exp_rk[r] = next_round(exp_rk[r-1], rcon(r-1));
    endtask

    function automatic logic [127:0] ref_read(input logic d, input int idx);
        if (idx > 10) return 128'h0;
        return d ? exp_rk[10-idx] : exp_rk[idx];
    endfunction

    // Expander stand-in: loads on kld, otherwise advances one round per clock.
    always @(posedge clk) begin
        if (kld) begin
            model_w  <= key_exp;
            model_r  <= 0;
            kld_seen <= kld_seen + 1;
        end else if (model_r < 16) begin
            model_w <= next_round(model_w, rcon(model_r));
            model_r <= model_r + 1;
        end
    end
    assign {wo_0, wo_1, wo_2, wo_3} = model_w;

    task automatic accept_key(input logic [127:0] key);
        @(posedge clk); #1;
        key_in  = key;
        key_vld = 1'b1;
        @(posedge clk); #1;
        key_vld = 1'b0;
    endtask

    task automatic wait_vld(output int n);
        n = 0;
        while (rk_vld !== 1'b1 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic read_rk(input logic d, input int idx, output logic [127:0] got);
        dec    = d;
        rd_idx = 4'(idx);
        @(posedge clk); #1;
        got = rk_out;
    endtask

    task automatic test_reset();
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        checks++; if (rk_vld !== 1'b0) begin fails++; $display("FAIL reset_rk_vld got=%b exp=0", rk_vld); end
        checks++; if (key_rdy !== 1'b1) begin fails++; $display("FAIL reset_key_rdy got=%b exp=1", key_rdy); end
        checks++; if (rk_out !== 128'h0) begin fails++; $display("FAIL reset_rk_out got=%h exp=0", rk_out); end
        checks++; if (kld !== 1'b0) begin fails++; $display("FAIL reset_kld got=%b exp=0", kld); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        $display("reset: asynchronous assert checked");
    endtask

    task automatic test_fips_forward();
        int n;
        logic [127:0] got;
        calc_expected(FIPS_KEY);
        accept_key(FIPS_KEY);
        wait_vld(n);
        checks++; if (n !== 11) begin fails++; $display("FAIL fwd_latency got=%0d exp=11", n); end
        read_rk(1'b0, 0, got);
        checks++; if (got !== FIPS_KEY) begin fails++; $display("FAIL fwd_idx0 got=%h exp=%h", got, FIPS_KEY); end
        read_rk(1'b0, 1, got);
        checks++; if (got !== FIPS_RK1) begin fails++; $display("FAIL fwd_idx1 got=%h exp=%h", got, FIPS_RK1); end
        read_rk(1'b0, 10, got);
        checks++; if (got !== FIPS_RK10) begin fails++; $display("FAIL fwd_idx10 got=%h exp=%h", got, FIPS_RK10); end
        for (int i = 0; i <= 10; i++) begin
            read_rk(1'b0, i, got);
            checks++;
            if (got !== ref_read(1'b0, i)) begin
                fails++; $display("FAIL fwd_all idx=%0d got=%h exp=%h", i, got, ref_read(1'b0, i));
            end
        end
        $display("fips_forward: latency=%0d rk10=%h", n, got);
    endtask

    task automatic test_fips_reverse();
        logic [127:0] got;
        int idx;
        logic d;
        read_rk(1'b1, 0, got);
        checks++; if (got !== FIPS_RK10) begin fails++; $display("FAIL rev_idx0 got=%h exp=%h", got, FIPS_RK10); end
        read_rk(1'b1, 10, got);
        checks++; if (got !== FIPS_KEY) begin fails++; $display("FAIL rev_idx10 got=%h exp=%h", got, FIPS_KEY); end
        read_rk(1'b1, 11, got);
        checks++; if (got !== 128'h0) begin fails++; $display("FAIL rev_idx11 got=%h exp=0", got); end
        read_rk(1'b0, 11, got);
        checks++; if (got !== 128'h0) begin fails++; $display("FAIL fwd_idx11 got=%h exp=0", got); end
        for (int i = 0; i < 16; i++) begin
            d   = 1'($urandom_range(0, 1));
            idx = int'($urandom_range(0, 15));
            read_rk(d, idx, got);
            checks++;
            if (got !== ref_read(d, idx)) begin
                fails++; $display("FAIL rand_read dec=%0d idx=%0d got=%h exp=%h", d, idx, got, ref_read(d, idx));
            end
        end
        $display("fips_reverse: reverse and out-of-range reads checked");
    endtask

    task automatic test_hold_vld();
        logic [127:0] k;
        logic [127:0] got;
        int kld0;
        k = {$urandom, $urandom, $urandom, $urandom};
        calc_expected(k);
        kld0 = kld_seen;
        @(posedge clk); #1;
        key_in  = k;
        key_vld = 1'b1;
        @(posedge clk); #1;
        for (int i = 1; i <= 11; i++) begin
            checks++; if (key_rdy !== 1'b0) begin fails++; $display("FAIL hold_key_rdy T%0d got=%b exp=0", i, key_rdy); end
            if (i == 5) key_in = ~k;
            @(posedge clk); #1;
        end
        key_vld = 1'b0;
        checks++; if (kld_seen - kld0 !== 1) begin fails++; $display("FAIL hold_kld_pulses got=%0d exp=1", kld_seen - kld0); end
        checks++; if (rk_vld !== 1'b1) begin fails++; $display("FAIL hold_rk_vld got=%b exp=1", rk_vld); end
        for (int i = 0; i <= 10; i++) begin
            read_rk(1'b0, i, got);
            checks++;
            if (got !== ref_read(1'b0, i)) begin
                fails++; $display("FAIL hold_store idx=%0d got=%h exp=%h", i, got, ref_read(1'b0, i));
            end
        end
        $display("hold_vld: key=%h kld pulses=%0d", k, kld_seen - kld0);
    endtask

    task automatic test_new_key_in_done();
        logic [127:0] old10;
        logic [127:0] got;
        int n;
        old10  = exp_rk[10];
        dec    = 1'b0;
        rd_idx = 4'd10;
        @(posedge clk); #1;
        key_in  = 128'h0;
        key_vld = 1'b1;
        @(posedge clk); #1;
        key_vld = 1'b0;
        checks++; if (rk_vld !== 1'b0) begin fails++; $display("FAIL done_accept_rk_vld got=%b exp=0", rk_vld); end
        checks++; if (rk_out !== old10) begin fails++; $display("FAIL done_accept_old_read got=%h exp=%h", rk_out, old10); end
        calc_expected(128'h0);
        wait_vld(n);
        checks++; if (n !== 11) begin fails++; $display("FAIL done_relatency got=%0d exp=11", n); end
        read_rk(1'b0, 10, got);
        checks++; if (got !== ZERO_RK10) begin fails++; $display("FAIL zero_idx10 got=%h exp=%h", got, ZERO_RK10); end
        $display("new_key_in_done: latency=%0d rk10=%h", n, got);
    endtask

    task automatic test_reset_mid();
        logic [127:0] got;
        int n;
        calc_expected(FIPS_KEY);
        accept_key(FIPS_KEY);
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++; if (rk_vld !== 1'b0) begin fails++; $display("FAIL mid_rst_rk_vld got=%b exp=0", rk_vld); end
        checks++; if (key_rdy !== 1'b1) begin fails++; $display("FAIL mid_rst_key_rdy got=%b exp=1", key_rdy); end
        checks++; if (rk_out !== 128'h0) begin fails++; $display("FAIL mid_rst_rk_out got=%h exp=0", rk_out); end
        @(posedge clk); #1 rst = 1'b0;
        read_rk(1'b0, 0, got);
        checks++; if (got !== 128'h0) begin fails++; $display("FAIL mid_rst_idle_read got=%h exp=0", got); end
        accept_key(FIPS_KEY);
        wait_vld(n);
        checks++; if (n !== 11) begin fails++; $display("FAIL mid_rst_latency got=%0d exp=11", n); end
        for (int i = 0; i <= 10; i++) begin
            for (int d = 0; d < 2; d++) begin
                read_rk(1'(d), i, got);
                checks++;
                if (got !== ref_read(1'(d), i)) begin
                    fails++; $display("FAIL mid_rst_store dec=%0d idx=%0d got=%h exp=%h", d, i, got, ref_read(1'(d), i));
                end
            end
        end
        $display("reset_mid: re-expansion latency=%0d", n);
    endtask

    task automatic test_random_keys();
        logic [127:0] k;
        logic [127:0] got;
        int n;
        int idx;
        logic d;
        for (int t = 0; t < 4; t++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            calc_expected(k);
            accept_key(k);
            read_rk(1'b0, 0, got);
            checks++; if (got !== 128'h0) begin fails++; $display("FAIL rand_busy_read got=%h exp=0", got); end
            wait_vld(n);
            checks++; if (n !== 10) begin fails++; $display("FAIL rand_latency got=%0d exp=10", n); end
            for (int i = 0; i < 12; i++) begin
                d   = 1'($urandom_range(0, 1));
                idx = int'($urandom_range(0, 15));
                read_rk(d, idx, got);
                checks++;
                if (got !== ref_read(d, idx)) begin
                    fails++; $display("FAIL rand_key_read dec=%0d idx=%0d got=%h exp=%h", d, idx, got, ref_read(d, idx));
                end
            end
            $display("random_key %0d: key=%h", t, k);
        end
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_fips_forward();
        test_fips_reverse();
        test_hold_vld();
        test_new_key_in_done();
        test_reset_mid();
        test_random_keys();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
